hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
- Parametrised successor to the current pipeline controller of the 3-stage RAT pipeline (fetch, decode/EX, writeback).
- Adds per-port operand forwarding selects, load-use stall detection, a configurable branch flush length and a drain-then-inject interrupt sequencer.
- Also keeps a saturating stall-cycle counter.
- Sits beside the decoder. Drives the PC controls, fetch-latch stall/flush, control-vector NOP and the operand bypass muxes in front of the ALU.

Parameters:
- REG_AW, 5, register-file address width.
- NUM_RD, 2, number of register read ports checked for hazards.
- FLUSH_CYCLES, 1, wrong-path cycles squashed after a taken branch. Legal range 1..7.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*REG_AW  decode-stage read addresses; port i is bits [i*REG_AW +: REG_AW].
- rd_en  in  NUM_RD  port i actually reads a register.
- ex_wr_addr  in  REG_AW  EX-stage destination.
- ex_wr_en  in  1  EX stage writes the register file.
- ex_is_load  in  1  EX result not available until WB (scratch/SP/IN source).
- wb_wr_addr  in  REG_AW  WB-stage destination.
- wb_wr_en  in  1  WB stage writes.
- branch_taken  in  1  EX-stage branch/call/ret resolved taken.
- int_req  in  1  external interrupt, level.
- int_enable  in  1  I flag.
- fwd_sel  out  2*NUM_RD  per port: 0 = regfile, 1 = EX result, 2 = WB data.
- pc_inc  out  1  PC increment.
- pc_load  out  1  PC load.
- pc_reset  out  1  PC reset.
- fetch_stall  out  1  hold fetch latch and ROM address.
- fetch_flush  out  1  clear fetch latch to NOP.
- dec_nop  out  1  inject NOP into control vector.
- int_inject  out  1  drive decoder INT.
- int_ack  out  1  one-cycle interrupt acknowledge.
- stall_count  out  CNT_W  saturating count of fetch_stall cycles.

Behaviour:
- States: RUN, FLUSH, INT_DRAIN, INT_INJECT. Registered: state, 3-bit flush counter, stall_count. All other outputs are combinational from state and inputs.
- Reset (rst = 1, that cycle):
  - Outputs: pc_reset = 1, fetch_flush = 1, dec_nop = 1; pc_inc = pc_load = int_inject = int_ack = fetch_stall = 0.
  - Next cycle: state = RUN, counter = 0, stall_count = 0.
  - Reset mid-FLUSH or mid-interrupt aborts the sequence; a pending int_req is not remembered.
- Forwarding (all states, combinational), per port i:
  - If rd_en[i] && ex_wr_en && ex_wr_addr == addr_i && !ex_is_load, then fwd_sel = 1.
  - Else if rd_en[i] && wb_wr_en && wb_wr_addr == addr_i, then fwd_sel = 2.
  - Else fwd_sel = 0.
  - EX has priority over WB. Address 0 is not special.
- Load-use stall (RUN only): any port with rd_en[i] && ex_wr_en && ex_is_load && ex_wr_addr == addr_i.
  - Outputs: fetch_stall = 1, dec_nop = 1, pc_inc = 0.
  - Lasts exactly 1 cycle: next cycle the load is in WB, so fwd_sel = 2.
- RUN priority, highest first: branch_taken > load-use > interrupt > normal.
  - Normal: pc_inc = 1, all else 0.
- Taken branch in RUN:
  - That cycle: pc_load = 1, pc_inc = 0, fetch_flush = 1, dec_nop = 1.
  - FLUSH_CYCLES == 1: stay in RUN.
  - Else: go to FLUSH with counter = FLUSH_CYCLES-1.
- FLUSH:
  - Outputs: fetch_flush = 1, dec_nop = 1, pc_inc = 1.
  - Counter decrements each cycle; leave for RUN when it reaches 1.
  - branch_taken and int_req are ignored while in FLUSH.
- Interrupt:
  - Accepted in RUN when int_req && int_enable and no taken branch or load-use that cycle. Go to INT_DRAIN.
  - INT_DRAIN (1 cycle): dec_nop = 1, fetch_stall = 1, pc_inc = 0, so the EX instruction retires. Then go to INT_INJECT.
  - INT_INJECT (1 cycle): int_inject = 1, int_ack = 1, pc_inc = 0. Then go to RUN.
  - A branch_taken arriving in INT_DRAIN is ignored; it cannot occur because EX holds a NOP.
  - int_req is level-sensitive; dropping it after acceptance does not cancel the sequence.
- stall_count increments on every cycle with fetch_stall = 1 and saturates at all-ones.

Test Plan:
- Reset: rst high 2 cycles -> pc_reset = 1, dec_nop = 1; after release stall_count = 0, pc_inc = 1, fwd_sel = 0.
- Forwarding: EX writes r5 (non-load), WB writes r5, decode reads r5 on port0 and r3 on port1 -> fwd_sel = {2'd0, 2'd1}. Drop ex_wr_en -> port0 sel = 2.
- Load-use: ex_is_load = 1 to r7, decode reads r7 -> 1 cycle of fetch_stall = 1, dec_nop = 1, pc_inc = 0, then sel = 2; stall_count = 1.
- Branch with FLUSH_CYCLES = 3: branch_taken pulse -> pc_load for 1 cycle; fetch_flush/dec_nop high 3 cycles; int_req during FLUSH deferred until RUN.
- Interrupt: int_enable = 1, int_req raised in RUN -> INT_DRAIN (fetch_stall = 1), then int_inject = int_ack = 1 for exactly 1 cycle, then RUN. With int_enable = 0 -> no response.
- Priority and saturation: branch_taken together with load-use and int_req -> only branch actions. With CNT_W = 4, drive 20 stall cycles -> stall_count = 15.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_ctrl
// Description : Pipeline hazard controller for the 3-stage RAT pipeline
//               (fetch, decode/EX, writeback). Produces the per-port operand
//               bypass selects, detects load-use hazards and stalls for them,
//               squashes wrong-path fetches after a taken branch, and runs a
//               drain-then-inject interrupt sequence. It also keeps a
//               saturating count of fetch-stall cycles.
//
// Ports       : clk, rst        - clock, synchronous active-high reset
//               rd_addr/rd_en   - decode-stage register read ports
//               ex_wr_*         - EX-stage destination, write enable, load flag
//               wb_wr_*         - WB-stage destination, write enable
//               branch_taken    - EX-stage branch resolved taken
//               int_req         - level-sensitive interrupt request
//               int_enable      - interrupt enable (I flag)
//               fwd_sel         - 2 bits per port: 0 regfile, 1 EX, 2 WB
//               pc_inc/pc_load/pc_reset - PC controls
//               fetch_stall/fetch_flush - fetch latch hold / clear to NOP
//               dec_nop         - force NOP into the control vector
//               int_inject      - drive decoder INT
//               int_ack         - one-cycle interrupt acknowledge
//               stall_count     - saturating count of fetch_stall cycles
//
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_ctrl #(
    parameter int REG_AW       = 5,
    parameter int NUM_RD       = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*REG_AW-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [REG_AW-1:0]        ex_wr_addr,
    input  logic                     ex_wr_en,
    input  logic                     ex_is_load,
    input  logic [REG_AW-1:0]        wb_wr_addr,
    input  logic                     wb_wr_en,
    input  logic                     branch_taken,
    input  logic                     int_req,
    input  logic                     int_enable,
    output logic [2*NUM_RD-1:0]      fwd_sel,
    output logic                     pc_inc,
    output logic                     pc_load,
    output logic                     pc_reset,
    output logic                     fetch_stall,
    output logic                     fetch_flush,
    output logic                     dec_nop,
    output logic                     int_inject,
    output logic                     int_ack,
    output logic [CNT_W-1:0]         stall_count
);

    localparam logic [1:0] c_ST_RUN        = 2'd0;
    localparam logic [1:0] c_ST_FLUSH      = 2'd1;
    localparam logic [1:0] c_ST_INT_DRAIN  = 2'd2;
    localparam logic [1:0] c_ST_INT_INJECT = 2'd3;

    // The branch cycle itself squashes one fetch, so FLUSH covers the rest.
    localparam logic [2:0] c_FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic       c_MULTI_FLUSH = (FLUSH_CYCLES > 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [2:0]       r_flush_cnt;
    logic [2:0]       w_flush_cnt_nxt;
    logic [CNT_W-1:0] r_stall_count;
    logic [NUM_RD-1:0] w_lu_hit;
    logic              w_load_use;

    // ------------------------------------------------------------------
    // Per-port bypass selection and load-use detection. A load in EX has
    // no result yet, so it never forwards from EX; it stalls instead and
    // the operand is picked up from WB on the following cycle.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_port
            logic [REG_AW-1:0] w_addr;
            logic              w_ex_match;
            logic              w_wb_match;

            assign w_addr     = rd_addr[gi*REG_AW +: REG_AW];
            assign w_ex_match = rd_en[gi] && ex_wr_en && (ex_wr_addr == w_addr);
            assign w_wb_match = rd_en[gi] && wb_wr_en && (wb_wr_addr == w_addr);
            assign w_lu_hit[gi] = w_ex_match && ex_is_load;

            always_comb begin
                fwd_sel[2*gi +: 2] = 2'd0;
                if (w_ex_match && !ex_is_load) begin
                    fwd_sel[2*gi +: 2] = 2'd1;
                end else if (w_wb_match) begin
                    fwd_sel[2*gi +: 2] = 2'd2;
                end
            end
        end : g_port
    endgenerate

    assign w_load_use = |w_lu_hit;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_RUN;
            r_flush_cnt <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and pipeline control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        pc_inc          = 1'b0;
        pc_load         = 1'b0;
        pc_reset        = 1'b0;
        fetch_stall     = 1'b0;
        fetch_flush     = 1'b0;
        dec_nop         = 1'b0;
        int_inject      = 1'b0;
        int_ack         = 1'b0;

        if (rst) begin
            pc_reset        = 1'b1;
            fetch_flush     = 1'b1;
            dec_nop         = 1'b1;
            w_state_nxt     = c_ST_RUN;
            w_flush_cnt_nxt = 3'd0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (branch_taken) begin
                        pc_load     = 1'b1;
                        fetch_flush = 1'b1;
                        dec_nop     = 1'b1;
                        if (c_MULTI_FLUSH) begin
                            w_state_nxt     = c_ST_FLUSH;
                            w_flush_cnt_nxt = c_FLUSH_INIT;
                        end
                    end else if (w_load_use) begin
                        fetch_stall = 1'b1;
                        dec_nop     = 1'b1;
                    end else if (int_req && int_enable) begin
                        // The decoding instruction proceeds normally; the
                        // drain cycle that follows lets it retire from EX.
                        pc_inc      = 1'b1;
                        w_state_nxt = c_ST_INT_DRAIN;
                    end else begin
                        pc_inc = 1'b1;
                    end
                end

                c_ST_FLUSH: begin
                    fetch_flush = 1'b1;
                    dec_nop     = 1'b1;
                    pc_inc      = 1'b1;
                    if (r_flush_cnt <= 3'd1) begin
                        w_state_nxt     = c_ST_RUN;
                        w_flush_cnt_nxt = 3'd0;
                    end else begin
                        w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                    end
                end

                c_ST_INT_DRAIN: begin
                    fetch_stall = 1'b1;
                    dec_nop     = 1'b1;
                    w_state_nxt = c_ST_INT_INJECT;
                end

                c_ST_INT_INJECT: begin
                    int_inject  = 1'b1;
                    int_ack     = 1'b1;
                    w_state_nxt = c_ST_RUN;
                end

                default: begin
                    w_state_nxt     = c_ST_RUN;
                    w_flush_cnt_nxt = 3'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (fetch_stall && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall_count = r_stall_count;

endmodule : hazard_forward_ctrl
`default_nettype wire

// File: tb/tb_hazard_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_forward_ctrl
// Description : Self-checking bench for hazard_forward_ctrl with
//               FLUSH_CYCLES = 3 and CNT_W = 4. Directed scenarios plus a
//               randomized run, all compared against a behavioural model
//               that tracks remaining flush cycles and interrupt phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_ctrl;

    localparam int c_AW  = 5;
    localparam int c_NRD = 2;
    localparam int c_FC  = 3;
    localparam int c_CW  = 4;

    logic                  clk;
    logic                  rst;
    logic [c_NRD*c_AW-1:0] rd_addr;
    logic [c_NRD-1:0]      rd_en;
    logic [c_AW-1:0]       ex_wr_addr;
    logic                  ex_wr_en;
    logic                  ex_is_load;
    logic [c_AW-1:0]       wb_wr_addr;
    logic                  wb_wr_en;
    logic                  branch_taken;
    logic                  int_req;
    logic                  int_enable;
    logic [2*c_NRD-1:0]    fwd_sel;
    logic                  pc_inc;
    logic                  pc_load;
    logic                  pc_reset;
    logic                  fetch_stall;
    logic                  fetch_flush;
    logic                  dec_nop;
    logic                  int_inject;
    logic                  int_ack;
    logic [c_CW-1:0]       stall_count;

    hazard_forward_ctrl #(
        .REG_AW       (c_AW),
        .NUM_RD       (c_NRD),
        .FLUSH_CYCLES (c_FC),
        .CNT_W        (c_CW)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .rd_addr      (rd_addr),
        .rd_en        (rd_en),
        .ex_wr_addr   (ex_wr_addr),
        .ex_wr_en     (ex_wr_en),
        .ex_is_load   (ex_is_load),
        .wb_wr_addr   (wb_wr_addr),
        .wb_wr_en     (wb_wr_en),
        .branch_taken (branch_taken),
        .int_req      (int_req),
        .int_enable   (int_enable),
        .fwd_sel      (fwd_sel),
        .pc_inc       (pc_inc),
        .pc_load      (pc_load),
        .pc_reset     (pc_reset),
        .fetch_stall  (fetch_stall),
        .fetch_flush  (fetch_flush),
        .dec_nop      (dec_nop),
        .int_inject   (int_inject),
        .int_ack      (int_ack),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: remaining squash cycles after the branch cycle,
    // interrupt phase (0 none, 1 drain, 2 inject) and the stall count.
    int          m_flush_left = 0;
    int          m_int_phase  = 0;
    int          m_stall      = 0;
    logic        e_lu;
    logic        e_fetch_stall;
    logic [15:0] e_vec;

    // Packed order: fwd_sel[3:0], pc_inc, pc_load, pc_reset, fetch_stall,
    // fetch_flush, dec_nop, int_inject, int_ack, stall_count[3:0]
    function automatic logic [15:0] dut_vec();
        return {fwd_sel, pc_inc, pc_load, pc_reset, fetch_stall,
                fetch_flush, dec_nop, int_inject, int_ack, stall_count};
    endfunction

    function automatic void model_outputs();
        logic [3:0]      f;
        logic [c_AW-1:0] a;
        logic pinc, pld, prst, fst, ffl, nop, inj, ack;
        f = '0;
        e_lu = 1'b0;
        for (int i = 0; i < c_NRD; i++) begin
            a = rd_addr[i*c_AW +: c_AW];
            if (rd_en[i] && ex_wr_en && ex_wr_addr == a && ex_is_load) e_lu = 1'b1;
            if (rd_en[i] && ex_wr_en && ex_wr_addr == a && !ex_is_load) f[i*2 +: 2] = 2'd1;
            else if (rd_en[i] && wb_wr_en && wb_wr_addr == a)           f[i*2 +: 2] = 2'd2;
        end
        {pinc, pld, prst, fst, ffl, nop, inj, ack} = 8'b0;
        if (rst) begin
            prst = 1'b1; ffl = 1'b1; nop = 1'b1;
        end else if (m_flush_left > 0) begin
            ffl = 1'b1; nop = 1'b1; pinc = 1'b1;
        end else if (m_int_phase == 1) begin
            fst = 1'b1; nop = 1'b1;
        end else if (m_int_phase == 2) begin
            inj = 1'b1; ack = 1'b1;
        end else if (branch_taken) begin
            pld = 1'b1; ffl = 1'b1; nop = 1'b1;
        end else if (e_lu) begin
            fst = 1'b1; nop = 1'b1;
        end else begin
            pinc = 1'b1;
        end
        e_fetch_stall = fst;
        e_vec = {f, pinc, pld, prst, fst, ffl, nop, inj, ack, 4'(m_stall)};
    endfunction

    function automatic void model_advance();
        model_outputs();
        if (rst) begin
            m_flush_left = 0; m_int_phase = 0; m_stall = 0;
        end else begin
            if (e_fetch_stall && m_stall < 15) m_stall = m_stall + 1;
            if (m_flush_left > 0)      m_flush_left = m_flush_left - 1;
            else if (m_int_phase == 1) m_int_phase = 2;
            else if (m_int_phase == 2) m_int_phase = 0;
            else if (branch_taken)     m_flush_left = c_FC - 1;
            else if (e_lu)             m_flush_left = 0;
            else if (int_req && int_enable) m_int_phase = 1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic clear_inputs();
        rd_addr = '0; rd_en = '0; ex_wr_addr = '0; ex_wr_en = 1'b0;
        ex_is_load = 1'b0; wb_wr_addr = '0; wb_wr_en = 1'b0;
        branch_taken = 1'b0; int_req = 1'b0; int_enable = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1; model_outputs(); checks++;
            if (dut_vec() !== e_vec || pc_reset !== 1'b1 || dec_nop !== 1'b1) begin
                failures++;
                $display("FAIL reset_active: got %h expected %h", dut_vec(), e_vec);
            end
            tick();
        end
        rst = 1'b0;
        #1; model_outputs(); checks++;
        if (dut_vec() !== e_vec || stall_count !== 4'd0 || pc_inc !== 1'b1 || fwd_sel !== 4'd0) begin
            failures++;
            $display("FAIL reset_release: got %h expected %h", dut_vec(), e_vec);
        end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        ex_wr_en = 1'b1; ex_wr_addr = 5'd5;
        wb_wr_en = 1'b1; wb_wr_addr = 5'd5;
        rd_en = 2'b11; rd_addr = {5'd3, 5'd5};
        #1; model_outputs(); checks++;
        if (fwd_sel !== 4'b0001 || dut_vec() !== e_vec) begin
            failures++;
            $display("FAIL fwd_ex_priority: got %h expected %h", dut_vec(), e_vec);
        end
        ex_wr_en = 1'b0;
        #1; model_outputs(); checks++;
        if (fwd_sel !== 4'b0010 || dut_vec() !== e_vec) begin
            failures++;
            $display("FAIL fwd_wb: got %h expected %h", dut_vec(), e_vec);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [3:0] start_cnt;
        clear_inputs();
        start_cnt = 4'(m_stall);
        ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_addr = 5'd7;
        rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
        #1; model_outputs(); checks++;
        if (fetch_stall !== 1'b1 || dec_nop !== 1'b1 || pc_inc !== 1'b0 || dut_vec() !== e_vec) begin
            failures++;
            $display("FAIL load_use_stall: got %h expected %h", dut_vec(), e_vec);
        end
        tick();
        ex_wr_en = 1'b0; ex_is_load = 1'b0;
        wb_wr_en = 1'b1; wb_wr_addr = 5'd7;
        #1; model_outputs(); checks++;
        if (fwd_sel[1:0] !== 2'd2 || fetch_stall !== 1'b0 ||
            stall_count !== start_cnt + 4'd1 || dut_vec() !== e_vec) begin
            failures++;
            $display("FAIL load_use_after: got %h expected %h", dut_vec(), e_vec);
        end
        tick();
    endtask

    task automatic test_branch();
        int flush_high;
        clear_inputs();
        branch_taken = 1'b1;
        #1; model_outputs(); checks++;
        if (pc_load !== 1'b1 || pc_inc !== 1'b0 || dut_vec() !== e_vec) begin
            failures++;
            $display("FAIL branch_load: got %h expected %h", dut_vec(), e_vec);
        end
        flush_high = (fetch_flush && dec_nop) ? 1 : 0;
        tick();
        branch_taken = 1'b0; int_req = 1'b1; int_enable = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1; model_outputs(); checks++;
            if (pc_load !== 1'b0 || fetch_stall !== 1'b0 || dut_vec() !== e_vec) begin
                failures++;
                $display("FAIL branch_flush: got %h expected %h", dut_vec(), e_vec);
            end
            if (fetch_flush && dec_nop) flush_high++;
            branch_taken = 1'b1;   // ignored while squashing
            tick();
            branch_taken = 1'b0;
        end
        #1; checks++;
        if (flush_high !== 3 || fetch_flush !== 1'b0) begin
            failures++;
            $display("FAIL branch_flush_len: got %0d expected 3", flush_high);
        end
        // Deferred interrupt is now accepted in RUN.
        model_outputs(); checks++;
        if (dut_vec() !== e_vec) begin
            failures++;
            $display("FAIL branch_int_accept: got %h expected %h", dut_vec(), e_vec);
        end
        tick();
        int_req = 1'b0;
        #1; model_outputs(); checks++;
        if (fetch_stall !== 1'b1 || dut_vec() !== e_vec) begin
            failures++;
            $display("FAIL branch_int_drain: got %h expected %h", dut_vec(), e_vec);
        end
        tick(); tick();
    endtask

    task automatic test_interrupt();
        clear_inputs();
        int_enable = 1'b1; int_req = 1'b1;
        tick();
        int_req = 1'b0;   // dropping the request must not cancel
        #1; model_outputs(); checks++;
        if (fetch_stall !== 1'b1 || dec_nop !== 1'b1 || pc_inc !== 1'b0 || dut_vec() !== e_vec) begin
            failures++;
            $display("FAIL int_drain: got %h expected %h", dut_vec(), e_vec);
        end
        tick();
        #1; model_outputs(); checks++;
        if (int_inject !== 1'b1 || int_ack !== 1'b1 || pc_inc !== 1'b0 || dut_vec() !== e_vec) begin
            failures++;
            $display("FAIL int_inject: got %h expected %h", dut_vec(), e_vec);
        end
        tick();
        #1; model_outputs(); checks++;
        if (int_ack !== 1'b0 || pc_inc !== 1'b1 || dut_vec() !== e_vec) begin
            failures++;
            $display("FAIL int_return: got %h expected %h", dut_vec(), e_vec);
        end
        int_enable = 1'b0; int_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1; model_outputs(); checks++;
            if (pc_inc !== 1'b1 || fetch_stall !== 1'b0 || int_ack !== 1'b0 || dut_vec() !== e_vec) begin
                failures++;
                $display("FAIL int_disabled: got %h expected %h", dut_vec(), e_vec);
            end
            tick();
        end
    endtask

    task automatic test_priority();
        clear_inputs();
        branch_taken = 1'b1; int_req = 1'b1; int_enable = 1'b1;
        ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_addr = 5'd9;
        rd_en = 2'b10; rd_addr = {5'd9, 5'd0};
        #1; model_outputs(); checks++;
        if (pc_load !== 1'b1 || fetch_stall !== 1'b0 || int_inject !== 1'b0 || dut_vec() !== e_vec) begin
            failures++;
            $display("FAIL priority_branch: got %h expected %h", dut_vec(), e_vec);
        end
        tick();
        clear_inputs();
        for (int c = 0; c < 3; c++) tick();
    endtask

    task automatic test_saturation();
        clear_inputs();
        ex_wr_en = 1'b1; ex_is_load = 1'b1; ex_wr_addr = 5'd2;
        rd_en = 2'b01; rd_addr = {5'd0, 5'd2};
        for (int c = 0; c < 20; c++) tick();
        #1; model_outputs(); checks++;
        if (stall_count !== 4'd15 || dut_vec() !== e_vec) begin
            failures++;
            $display("FAIL stall_saturate: got %h expected %h", dut_vec(), e_vec);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 500; c++) begin
            rst          = ($urandom_range(0, 40) == 0);
            rd_addr      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            rd_en        = 2'($urandom);
            ex_wr_addr   = 5'($urandom_range(0, 3));
            ex_wr_en     = 1'($urandom);
            ex_is_load   = ($urandom_range(0, 3) == 0);
            wb_wr_addr   = 5'($urandom_range(0, 3));
            wb_wr_en     = 1'($urandom);
            branch_taken = ($urandom_range(0, 7) == 0);
            int_req      = ($urandom_range(0, 3) == 0);
            int_enable   = 1'($urandom);
            #1; model_outputs(); checks++;
            if (dut_vec() !== e_vec) begin
                failures++;
                if (errs < 10)
                    $display("FAIL random_cycle%0d: got %h expected %h", c, dut_vec(), e_vec);
                errs++;
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        test_reset();
        tick();
        test_forwarding();
        test_load_use();
        test_branch();
        test_interrupt();
        test_priority();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hazard_forward_ctrl
`default_nettype wire
